// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates Ex jumps, Clint traps, Mem stalls and load-use holds
// into the shared HoldFlag/JumpAddr buses, buffering jumps that arrive during a stall.
module fetch_redirect_ctrl #(
    parameter int ADDR_W       = 64,
    parameter int TRAP_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              JumpFlagFromEx,
    input  logic [ADDR_W-1:0] JumpAddrFromEx,
    input  logic              LoadUseFromId,
    input  logic              MemBusyFromMem,
    input  logic              TrapReqFromClint,
    input  logic [ADDR_W-1:0] TrapAddrFromClint,
    input  logic              HoldFlagEndFromClint,
    output logic [2:0]        HoldFlagToPipe,
    output logic [ADDR_W-1:0] JumpAddrToPc,
    output logic              TrapAckToClint,
    output logic              TrapTimeout
);
    typedef enum logic [1:0] {IDLE, MEM_STALL, TRAP_WAIT} state_t;

    localparam logic [7:0] TMO = 8'(TRAP_TIMEOUT);

    state_t            state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] trap_q, trap_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic              tmo_q, tmo_d;
    logic [2:0]        hold;
    logic [ADDR_W-1:0] addr;
    logic              ack;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        trap_d   = trap_q;
        cnt_d    = '0;
        tmo_d    = tmo_q;
        hold     = 3'b000;
        addr     = '0;
        ack      = 1'b0;
        case (state_q)
            IDLE: begin
                if (TrapReqFromClint && !MemBusyFromMem) begin
                    hold    = 3'b011;
                    addr    = TrapAddrFromClint;
                    ack     = 1'b1;
                    trap_d  = TrapAddrFromClint;
                    state_d = TRAP_WAIT;
                end else if (MemBusyFromMem) begin
                    hold    = 3'b100;
                    state_d = MEM_STALL;
                    if (JumpFlagFromEx) begin
                        pend_v_d = 1'b1;
                        pend_d   = JumpAddrFromEx;
                    end
                end else if (JumpFlagFromEx) begin
                    hold = 3'b001;
                    addr = JumpAddrFromEx;
                end else if (LoadUseFromId) begin
                    hold = 3'b010;
                end
            end
            MEM_STALL: begin
                if (MemBusyFromMem) begin
                    hold = 3'b100;
                    // first jump seen during the stall wins
                    if (JumpFlagFromEx && !pend_v_q) begin
                        pend_v_d = 1'b1;
                        pend_d   = JumpAddrFromEx;
                    end
                end else begin
                    pend_v_d = 1'b0;
                    state_d  = IDLE;
                    if (TrapReqFromClint) begin
                        hold    = 3'b011;
                        addr    = TrapAddrFromClint;
                        ack     = 1'b1;
                        trap_d  = TrapAddrFromClint;
                        state_d = TRAP_WAIT;
                    end else if (pend_v_q) begin
                        hold = 3'b001;
                        addr = pend_q;
                    end
                end
            end
            TRAP_WAIT: begin
                hold = 3'b011;
                addr = trap_q;
                if (HoldFlagEndFromClint) begin
                    state_d = IDLE;
                end else if (cnt_inc >= TMO) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // reset forces the flush-all code immediately, independent of the clock
    assign HoldFlagToPipe = Rst ? hold : 3'b111;
    assign JumpAddrToPc   = Rst ? addr : '0;
    assign TrapAckToClint = Rst & ack;
    assign TrapTimeout    = tmo_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            trap_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            trap_q   <= trap_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed checks of hold/redirect arbitration, stall buffering,
// trap handshake, timeout watchdog and asynchronous reset.
module tb_fetch_redirect_ctrl;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        JumpFlagFromEx;
    logic [63:0] JumpAddrFromEx;
    logic        LoadUseFromId;
    logic        MemBusyFromMem;
    logic        TrapReqFromClint;
    logic [63:0] TrapAddrFromClint;
    logic        HoldFlagEndFromClint;
    logic [2:0]  HoldFlagToPipe;
    logic [63:0] JumpAddrToPc;
    logic        TrapAckToClint;
    logic        TrapTimeout;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;

    fetch_redirect_ctrl #(.ADDR_W(64), .TRAP_TIMEOUT(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .JumpFlagFromEx(JumpFlagFromEx), .JumpAddrFromEx(JumpAddrFromEx),
        .LoadUseFromId(LoadUseFromId), .MemBusyFromMem(MemBusyFromMem),
        .TrapReqFromClint(TrapReqFromClint), .TrapAddrFromClint(TrapAddrFromClint),
        .HoldFlagEndFromClint(HoldFlagEndFromClint),
        .HoldFlagToPipe(HoldFlagToPipe), .JumpAddrToPc(JumpAddrToPc),
        .TrapAckToClint(TrapAckToClint), .TrapTimeout(TrapTimeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst = 1'b0;
        JumpFlagFromEx = 1'b0; JumpAddrFromEx = '0; LoadUseFromId = 1'b0;
        MemBusyFromMem = 1'b0; TrapReqFromClint = 1'b0; TrapAddrFromClint = '0;
        HoldFlagEndFromClint = 1'b0;
        #1;
        chk("rst_hold", HoldFlagToPipe, 3'b111);
        chk("rst_addr", JumpAddrToPc, 0);
        chk("rst_ack", TrapAckToClint, 0);
        chk("rst_tmo", TrapTimeout, 0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("run_hold", HoldFlagToPipe, 3'b000);
        chk("run_tmo", TrapTimeout, 0);

        // jump beats load-use, then load-use alone
        @(negedge Clk);
        JumpFlagFromEx = 1'b1; JumpAddrFromEx = 64'h8000_0100; LoadUseFromId = 1'b1;
        #1;
        chk("jmp_hold", HoldFlagToPipe, 3'b001);
        chk("jmp_addr", JumpAddrToPc, 64'h8000_0100);
        @(negedge Clk);
        JumpFlagFromEx = 1'b0;
        #1;
        chk("lu_hold", HoldFlagToPipe, 3'b010);
        @(negedge Clk);
        LoadUseFromId = 1'b0;

        // four-cycle mem stall with two jumps; the first one is replayed
        MemBusyFromMem = 1'b1;
        #1;
        chk("ms1_hold", HoldFlagToPipe, 3'b100);
        @(negedge Clk);
        JumpFlagFromEx = 1'b1; JumpAddrFromEx = 64'h8000_0200;
        #1;
        chk("ms2_hold", HoldFlagToPipe, 3'b100);
        @(negedge Clk);
        JumpAddrFromEx = 64'h8000_0300;
        #1;
        chk("ms3_hold", HoldFlagToPipe, 3'b100);
        @(negedge Clk);
        JumpFlagFromEx = 1'b0;
        #1;
        chk("ms4_hold", HoldFlagToPipe, 3'b100);
        @(negedge Clk);
        MemBusyFromMem = 1'b0;
        #1;
        chk("ms_rel_hold", HoldFlagToPipe, 3'b001);
        chk("ms_rel_addr", JumpAddrToPc, 64'h8000_0200);
        @(negedge Clk);
        #1;
        chk("ms_after", HoldFlagToPipe, 3'b000);

        // trap wins over simultaneous jump, End after 5 cycles
        @(negedge Clk);
        TrapReqFromClint = 1'b1; TrapAddrFromClint = 64'h8000_0004;
        JumpFlagFromEx = 1'b1; JumpAddrFromEx = 64'h8000_0400;
        #1;
        ack_cnt += int'(TrapAckToClint);
        chk("trap_ack", TrapAckToClint, 1);
        chk("trap_hold", HoldFlagToPipe, 3'b011);
        chk("trap_addr", JumpAddrToPc, 64'h8000_0004);
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            JumpFlagFromEx = 1'b0;
            TrapReqFromClint = (i == 1);
            HoldFlagEndFromClint = (i == 5);
            #1;
            ack_cnt += int'(TrapAckToClint);
            chk("tw_hold", HoldFlagToPipe, 3'b011);
            chk("tw_addr", JumpAddrToPc, 64'h8000_0004);
        end
        @(negedge Clk);
        HoldFlagEndFromClint = 1'b0;
        #1;
        ack_cnt += int'(TrapAckToClint);
        chk("end_hold", HoldFlagToPipe, 3'b000);
        chk("ack_count", ack_cnt, 1);

        // timeout after 8 TRAP_WAIT cycles without End
        @(negedge Clk);
        TrapReqFromClint = 1'b1; TrapAddrFromClint = 64'h8000_0008;
        #1;
        chk("to_ack", TrapAckToClint, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            TrapReqFromClint = 1'b0;
            #1;
            chk("to_wait_hold", HoldFlagToPipe, 3'b011);
            chk("to_wait_flag", TrapTimeout, 0);
        end
        @(negedge Clk);
        #1;
        chk("to_hold", HoldFlagToPipe, 3'b000);
        chk("to_flag", TrapTimeout, 1);
        repeat (3) @(negedge Clk);
        #1;
        chk("to_sticky", TrapTimeout, 1);

        // async reset mid-stall drops the pending jump
        @(negedge Clk);
        MemBusyFromMem = 1'b1; JumpFlagFromEx = 1'b1; JumpAddrFromEx = 64'h8000_0500;
        #1;
        chk("ar_hold", HoldFlagToPipe, 3'b100);
        @(negedge Clk);
        JumpFlagFromEx = 1'b0;
        #3;
        Rst = 1'b0;
        #1;
        chk("ar_rst_hold", HoldFlagToPipe, 3'b111);
        chk("ar_rst_addr", JumpAddrToPc, 0);
        chk("ar_rst_ack", TrapAckToClint, 0);
        chk("ar_rst_tmo", TrapTimeout, 0);
        @(negedge Clk);
        MemBusyFromMem = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("ar_rel_hold", HoldFlagToPipe, 3'b000);
        @(negedge Clk);
        #1;
        chk("ar_rel_hold2", HoldFlagToPipe, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Central hold/redirect scheduler for the Pc register and the If/Id/Ex pipeline registers.
- Arbitrates between four requesters and drives the shared 3-bit HoldFlag bus and the JumpAddr bus that Pc consumes:
  - Ex branch/jump.
  - Clint trap entry.
  - Mem-stage bus stall.
  - Id load-use stall.
- Buffers a redirect that arrives while the pipe is frozen, and sequences the trap handshake with Clint, including a timeout watchdog.

Parameters:
ADDR_W, 64, width of all address buses.
TRAP_TIMEOUT, 255, maximum cycles spent in TRAP_WAIT before the timeout error is raised (8-bit counter; legal range 1..255).

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst  in  1  asynchronous, active-low reset.
JumpFlagFromEx  in  1  Ex resolved taken branch/jump; single-cycle pulse.
JumpAddrFromEx  in  ADDR_W  target, valid with JumpFlagFromEx.
LoadUseFromId  in  1  level; Id detected a load-use hazard.
MemBusyFromMem  in  1  level; Mem stage waiting on the bus.
TrapReqFromClint  in  1  level; held by Clint until TrapAckToClint.
TrapAddrFromClint  in  ADDR_W  trap vector, valid with TrapReqFromClint.
HoldFlagEndFromClint  in  1  pulse; Clint finished CSR save, so Pc may load the trap vector.
HoldFlagToPipe  out  3  hold/flush code (see below).
JumpAddrToPc  out  ADDR_W  redirect address.
TrapAckToClint  out  1  one-cycle acceptance pulse.
TrapTimeout  out  1  sticky error flag.

Behaviour:
- HoldFlag codes:
  - 000: run.
  - 001: flush If/Id and load JumpAddr into Pc.
  - 010: hold Pc and If/Id (load-use).
  - 011: trap wait (Pc loads JumpAddr only when HoldFlagEndFromClint=1).
  - 100: hold the whole pipe (mem stall).
  - 111: flush all.
- Outputs are combinational from the registered state and the current inputs (zero-cycle response). State, the pending register and the counter are registered.
- Reset (Rst=0, asynchronous):
  - State=IDLE, pending cleared, counter=0, TrapTimeout=0.
  - Outputs: HoldFlagToPipe=111, JumpAddrToPc=0, TrapAckToClint=0.
- States:
  - IDLE, per-cycle priority, highest first:
    1. TrapReq && !MemBusy: HoldFlag=011, JumpAddr=TrapAddr, TrapAck=1; latch TrapAddr; go to TRAP_WAIT. Any simultaneous Ex jump is discarded, because the epc is taken by Clint.
    2. MemBusy: HoldFlag=100. If JumpFlagFromEx, latch JumpAddrFromEx into pending (pend_v=1). Go to MEM_STALL.
    3. JumpFlagFromEx: HoldFlag=001, JumpAddr=JumpAddrFromEx.
    4. LoadUseFromId: HoldFlag=010.
    5. Otherwise HoldFlag=000.
  - MEM_STALL:
    - While MemBusy=1: HoldFlag=100. A new Ex jump while pend_v=0 is latched; the first latched jump wins, and later ones are ignored.
    - When MemBusy=0:
      - If TrapReq: take the trap exactly as in IDLE and clear pend_v.
      - Else if pend_v=1: HoldFlag=001, JumpAddr=pending, clear pend_v.
      - Else HoldFlag=000.
      - Go to the state selected by the branch above: TRAP_WAIT for a trap, otherwise IDLE.
  - TRAP_WAIT:
    - HoldFlag=011, JumpAddr=latched trap vector; all other requesters are ignored.
    - Counter increments each cycle.
    - On HoldFlagEndFromClint=1: go to IDLE and clear the counter. Pc loads the vector on the same edge.
    - If the counter reaches TRAP_TIMEOUT without End: set TrapTimeout (sticky until reset) and go to IDLE. HoldFlag is 000 from the next cycle.
- Arithmetic:
  - The counter saturates and never wraps.
  - The TrapAck pulse is exactly one cycle per accepted trap.
  - A TrapReq still high in the cycle after Ack, while in TRAP_WAIT, is not re-acked.
- Reset mid-TRAP_WAIT or mid-MEM_STALL: pending and the latched vector are discarded, and no Ack is issued.

Test Plan:
1. Reset: Rst low for 3 cycles, then high with all requests idle -> HoldFlag=111 during reset; from the first cycle after release HoldFlag=000, TrapTimeout=0.
2. Ex jump plus load-use: in IDLE, JumpFlag=1 with JumpAddr=0x8000_0100 and LoadUse=1 in the same cycle -> HoldFlag=001, JumpAddrToPc=0x8000_0100. Next cycle, LoadUse only -> 010.
3. Jump during mem stall: MemBusy=1 for 4 cycles; jump to 0x8000_0200 in stall cycle 2 and to 0x8000_0300 in stall cycle 3 -> HoldFlag=100 throughout the stall. In the cycle MemBusy falls, HoldFlag=001 with address 0x8000_0200; the next cycle is 000.
4. Trap versus jump: in IDLE, TrapReq with vector 0x8000_0004 and JumpFlag (0x8000_0400) together -> TrapAck=1 for one cycle, HoldFlag=011, JumpAddr=0x8000_0004, jump dropped. HoldFlagEnd arrives 5 cycles later -> HoldFlag=011 on that cycle, 000 afterwards, only one Ack observed.
5. Trap timeout: TRAP_TIMEOUT=8, TrapReq accepted, no End -> TrapTimeout rises after 8 TRAP_WAIT cycles, state returns to IDLE (HoldFlag=000), flag stays 1 until Rst.
6. Async reset mid-stall: MemBusy=1 with a latched pending jump; assert Rst between clock edges -> outputs go to the reset values immediately. After release with MemBusy=0, no 001 is issued.
